// File: rtl/knn_pkg.sv
// Shared constants and state type for the kNN local-buffer streaming path.
package knn_pkg;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } stream_state_t;

endpackage

// File: rtl/knn_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push and pop may
// coincide in any cycle, including when full.
module knn_sync_fifo #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  output logic [DATA_W-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; count is untouched on push+pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array, written only; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/knn_local_buf_streamer.sv
// Streams a contiguous (wrapping) range of the local sample buffer onto a
// valid/ready interface. Reads are issued only when the output FIFO has room
// for every word already in flight, so back-pressure never drops data.
module knn_local_buf_streamer #(
  parameter int unsigned DATA_W = knn_pkg::DATA_W,
  parameter int unsigned ADDR_W = knn_pkg::ADDR_W,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned FIFO_D = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address0,
  output logic              mem_ce0,
  output logic              mem_we0,
  output logic [DATA_W-1:0] mem_d0,
  input  logic [DATA_W-1:0] mem_q0,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  import knn_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_D) + 1;
  localparam int unsigned SW = CW + 1;

  stream_state_t     state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W:0]   remaining;
  logic [RD_LAT-1:0] vld_sr;
  logic [SW-1:0]     inflight;
  logic [SW-1:0]     occupancy;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              issue;
  logic              pop;
  logic              last_pop;

  assign mem_we0 = 1'b0;
  assign mem_d0  = '0;

  // Count reads issued but not yet written into the FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + SW'(vld_sr[i]);
  end

  assign occupancy    = SW'(fifo_count) + inflight;
  assign issue        = (state == RUN) && !fifo_full && (occupancy < SW'(FIFO_D));
  assign mem_ce0      = issue;
  // Address presents the new word only while reading; otherwise it parks on the last read.
  assign mem_address0 = issue ? next_addr : last_addr;

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (inflight == '0) && (fifo_count == CW'(1));

  // Valid shift register aligned so its tail coincides with q0 of the matching read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  knn_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (vld_sr[RD_LAT-1]),
    .push_data (mem_q0),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Control FSM with registered busy/done. FIN lasts two cycles for an empty
  // request (busy cycle then done cycle) and one cycle otherwise, because the
  // normal path raises done already on the final handshake edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      next_addr <= '0;
      last_addr <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= FIN;
            end else begin
              state     <= RUN;
              remaining <= len;
              next_addr <= base_addr;
            end
          end
        end
        RUN: begin
          if (issue) begin
            next_addr <= next_addr + 1'b1;
            last_addr <= next_addr;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop || (inflight == '0 && fifo_empty)) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FIN: begin
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_local_buf_streamer.sv
// Self-checking bench for knn_local_buf_streamer: buffer model with registered
// read pipeline (mem[i] = i), randomized back-pressure, model-based expectations.
module tb_knn_local_buf_streamer;

  localparam int DW     = 256;
  localparam int AW     = 11;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = 8;
  localparam int NWORDS = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done;
  logic [AW-1:0] mem_address0;
  logic          mem_ce0, mem_we0;
  logic [DW-1:0] mem_d0, mem_q0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  knn_local_buf_streamer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .RD_LAT (RD_LAT),
    .FIFO_D (FIFO_D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .mem_address0 (mem_address0),
    .mem_ce0      (mem_ce0),
    .mem_we0      (mem_we0),
    .mem_d0       (mem_d0),
    .mem_q0       (mem_q0),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  // Buffer model: mem[i] = i, data appears RD_LAT cycles after the ce0 cycle.
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_ce0) rd_pipe[0] <= DW'(mem_address0);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_q0 = rd_pipe[RD_LAT-1];

  function automatic int exp_word(input int base, input int k);
    return (base + k) % NWORDS;
  endfunction

  // Observations of one transfer (cycle 0 = start cycle).
  logic [DW-1:0] beat_data [$];
  int            beat_cyc  [$];
  int first_valid, done_cyc, done_cnt, ce_cnt, pops;
  int addr_err, we_err, stab_err, credit_err;
  logic busy_c1, busy_at_done;

  // Drives one request and records what the DUT does; judgement is left to the tests.
  task automatic run_xfer(input int base, input int n, input int ready_pct,
                          input bit restart, input int abort_beats);
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            budget     = 20 * n + 60;
    beat_data.delete(); beat_cyc.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; ce_cnt = 0; pops = 0;
    addr_err = 0; we_err = 0; stab_err = 0; credit_err = 0;
    busy_c1 = 1'b0; busy_at_done = 1'bx;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b1; base_addr = AW'(base); len = (AW+1)'(n);
      end else if (c == 1 && restart) begin
        start = 1'b1; base_addr = AW'(100); len = (AW+1)'(5);
      end else begin
        start = 1'b0;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (mem_ce0) begin
        if (int'(mem_address0) != exp_word(base, ce_cnt)) addr_err++;
        if (ce_cnt + 1 - pops > FIFO_D) credit_err++;
        ce_cnt++;
      end
      if (mem_we0 !== 1'b0 || mem_d0 !== '0) we_err++;
      if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && out_ready) begin
        beat_data.push_back(out_data);
        beat_cyc.push_back(c);
        pops++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (c == 1) busy_c1 = busy;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; busy_at_done = busy; end
      end
      if (abort_beats > 0 && pops == abort_beats) break;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    #2;
    n_assert++;
    if ({busy, done, out_valid, mem_ce0, mem_we0} !== 5'b0 || out_data !== '0 || mem_address0 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b ce=%b we=%b addr=%0d required all 0",
               busy, done, out_valid, mem_ce0, mem_we0, mem_address0);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    n_assert++;
    if ({busy, done, out_valid, mem_ce0} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b valid=%b ce=%b required 0", busy, done, out_valid, mem_ce0);
    end
  endtask

  task automatic test_basic();
    run_xfer(0, 16, 100, 1'b0, 0);
    n_assert++;
    if (first_valid !== RD_LAT + 2) begin
      n_fail++; $display("FAIL basic_first_valid: got cycle %0d required %0d", first_valid, RD_LAT + 2);
    end
    n_assert++;
    if (beat_data.size() !== 16) begin
      n_fail++; $display("FAIL basic_beats: got %0d required 16", beat_data.size());
    end
    for (int k = 0; k < beat_data.size(); k++) begin
      n_assert++;
      if (beat_data[k] !== DW'(exp_word(0, k)) || beat_cyc[k] !== RD_LAT + 2 + k) begin
        n_fail++;
        $display("FAIL basic_beat%0d: data %0d at cycle %0d required %0d at %0d",
                 k, beat_data[k][31:0], beat_cyc[k], exp_word(0, k), RD_LAT + 2 + k);
      end
    end
    n_assert++;
    if (done_cyc !== RD_LAT + 2 + 16 || done_cnt !== 1) begin
      n_fail++; $display("FAIL basic_done: cycle %0d count %0d required cycle %0d count 1", done_cyc, done_cnt, RD_LAT + 18);
    end
    n_assert++;
    if (ce_cnt !== 16 || addr_err !== 0) begin
      n_fail++; $display("FAIL basic_reads: ce %0d addr_err %0d required 16 and 0", ce_cnt, addr_err);
    end
    n_assert++;
    if (busy_c1 !== 1'b1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy: at T+1 %b at done %b required 1 and 0", busy_c1, busy_at_done);
    end
  endtask

  task automatic test_wrap();
    run_xfer(2040, 16, 100, 1'b0, 0);
    n_assert++;
    if (beat_data.size() !== 16) begin
      n_fail++; $display("FAIL wrap_beats: got %0d required 16", beat_data.size());
    end
    for (int k = 0; k < beat_data.size(); k++) begin
      n_assert++;
      if (beat_data[k] !== DW'(exp_word(2040, k))) begin
        n_fail++; $display("FAIL wrap_beat%0d: got %0d required %0d", k, beat_data[k][31:0], exp_word(2040, k));
      end
    end
    n_assert++;
    if (addr_err !== 0 || ce_cnt !== 16 || done_cnt !== 1) begin
      n_fail++; $display("FAIL wrap_addr: addr_err %0d ce %0d done %0d required 0 16 1", addr_err, ce_cnt, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    run_xfer(300, 64, 30, 1'b0, 0);
    n_assert++;
    if (beat_data.size() !== 64) begin
      n_fail++; $display("FAIL bp_beats: got %0d required 64", beat_data.size());
    end
    for (int k = 0; k < beat_data.size(); k++) begin
      n_assert++;
      if (beat_data[k] !== DW'(exp_word(300, k))) begin
        n_fail++; $display("FAIL bp_beat%0d: got %0d required %0d", k, beat_data[k][31:0], exp_word(300, k));
      end
    end
    n_assert++;
    if (stab_err !== 0 || credit_err !== 0) begin
      n_fail++; $display("FAIL bp_stall: unstable %0d over_credit %0d required 0 0", stab_err, credit_err);
    end
    n_assert++;
    if (beat_cyc.size() == 0 || done_cyc !== beat_cyc[beat_cyc.size()-1] + 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL bp_done: cycle %0d count %0d required last beat+1 and 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_zero_len();
    run_xfer(0, 0, 100, 1'b1, 0);
    n_assert++;
    if (ce_cnt !== 0 || beat_data.size() !== 0) begin
      n_fail++; $display("FAIL zero_reads: ce %0d beats %0d required 0 0", ce_cnt, beat_data.size());
    end
    n_assert++;
    if (done_cyc !== 2 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_done: cycle %0d count %0d required 2 1", done_cyc, done_cnt);
    end
    n_assert++;
    if (busy_c1 !== 1'b1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy: at T+1 %b at done %b required 1 0", busy_c1, busy_at_done);
    end
  endtask

  task automatic test_reset_mid();
    run_xfer(0, 32, 100, 1'b0, 10);
    #2 reset = 1'b1;
    #1;
    n_assert++;
    if ({busy, done, out_valid, mem_ce0} !== 4'b0 || out_data !== '0 || mem_address0 !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b done=%b valid=%b ce=%b addr=%0d required all 0",
               busy, done, out_valid, mem_ce0, mem_address0);
    end
    n_assert++;
    if (done_cnt !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    run_xfer(5, 4, 100, 1'b0, 0);
    n_assert++;
    if (beat_data.size() !== 4) begin
      n_fail++; $display("FAIL restart_beats: got %0d required 4", beat_data.size());
    end
    for (int k = 0; k < beat_data.size(); k++) begin
      n_assert++;
      if (beat_data[k] !== DW'(exp_word(5, k))) begin
        n_fail++; $display("FAIL restart_beat%0d: got %0d required %0d", k, beat_data[k][31:0], exp_word(5, k));
      end
    end
    n_assert++;
    if (done_cnt !== 1 || first_valid !== RD_LAT + 2) begin
      n_fail++; $display("FAIL restart_timing: done %0d first_valid %0d required 1 %0d", done_cnt, first_valid, RD_LAT + 2);
    end
  endtask

  task automatic test_full_len();
    int bad = 0;
    run_xfer(0, NWORDS, 100, 1'b0, 0);
    for (int k = 0; k < beat_data.size(); k++)
      if (beat_data[k] !== DW'(exp_word(0, k)) || beat_cyc[k] !== RD_LAT + 2 + k) bad++;
    n_assert++;
    if (beat_data.size() !== NWORDS || bad !== 0) begin
      n_fail++; $display("FAIL full_stream: beats %0d bad %0d required %0d 0", beat_data.size(), bad, NWORDS);
    end
    n_assert++;
    if (ce_cnt !== NWORDS || addr_err !== 0) begin
      n_fail++; $display("FAIL full_reads: ce %0d addr_err %0d required %0d 0", ce_cnt, addr_err, NWORDS);
    end
    n_assert++;
    if (done_cnt !== 1 || we_err !== 0) begin
      n_fail++; $display("FAIL full_done_we: done %0d we_err %0d required 1 0", done_cnt, we_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_full_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
